uart_tx_scheduler: RTL and testbench

//  Buffers CPU byte writes to the UART data register in a FIFO and sequences them into the

---
 rtl/uart_tx_pkg.sv | 13 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_tx_scheduler.sv | 111 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared STATUS bit positions and scheduler FSM states for the UART transmit path.
package uart_tx_pkg;

  localparam int unsigned ST_ACT  = 8;
  localparam int unsigned ST_BUSY = 9;
  localparam int unsigned ST_OVF  = 10;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; exposes the head entry and the one behind it
// so the consumer can reload back-to-back on a pop.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] head_next
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_inc;
  logic [AW:0]      count_q;
  logic             push_en, pop_en;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign push_en    = push & ~full;
  assign pop_en     = pop & ~empty;
  assign rd_ptr_inc = rd_ptr_q + AW'(1);
  assign head       = mem_q[rd_ptr_q];
  assign head_next  = mem_q[rd_ptr_inc];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_inc;
      count_q <= count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    end
  end

  // Storage is not reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Queues CPU writes to the UART DATA word and feeds them to the byte emitter over valid/ready.
// Optional UART_TX_IRQ_EN adds a registered irq output (idle-and-empty or overflow).
module uart_tx_scheduler
  import uart_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel_dat,
  input  logic        sel_cntl,
  input  logic        wstrb,
  input  logic        rstrb,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  state_e      state_q;
  logic        ovf_q, ovf_d;
  logic        full, empty;
  logic [AW:0] fifo_count, cnt_nxt;
  logic [7:0]  head, head_next, next_byte;
  logic        push_req, push_ok, hs;

  assign push_req = sel_dat & wstrb;
  assign push_ok  = push_req & ~full;
  assign hs       = tx_valid & tx_ready;
  assign cnt_nxt  = fifo_count + (AW+1)'(push_ok) - (AW+1)'(hs);
  assign ovf_d    = (push_req & full) | (ovf_q & ~(sel_cntl & rstrb));
  // With one entry left, the follow-on byte is the one being written this very edge.
  assign next_byte = (fifo_count == (AW+1)'(1)) ? wdata : head_next;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_ok),
    .pop       (hs),
    .wdata     (wdata),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count),
    .head      (head),
    .head_next (head_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            tx_data  <= head;
            tx_valid <= 1'b1;
            state_q  <= StSend;
          end
        end
        StSend: begin
          if (hs) begin
            if (cnt_nxt != '0) begin
              tx_data <= next_byte;
            end else begin
              tx_valid <= 1'b0;
              state_q  <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_cntl) begin
      rdata[ST_BUSY] = full;
      rdata[ST_OVF]  = ovf_q;
      rdata[ST_ACT]  = (state_q != StIdle);
      rdata[AW:0]    = fifo_count;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_q;

  // An empty FIFO after the edge always means the FSM is (or returns to) idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq_q <= 1'b0;
    else         irq_q <= (cnt_nxt == '0) | ovf_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the transmit path.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sel_dat, sel_cntl, wstrb, rstrb, tx_ready;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .sel_dat  (sel_dat),
    .sel_cntl (sel_cntl),
    .wstrb    (wstrb),
    .rstrb    (rstrb),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
`ifdef UART_TX_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: bytes accepted but not yet handed off, plus what the emitter currently sees.
  logic [7:0] mq[$];
  logic       m_valid, m_ovf, m_irq;
  logic [7:0] m_data;

  logic        got_valid;
  logic [7:0]  got_data;
  logic [31:0] got_rdata;

  typedef struct {
    logic        sd, sc, ws, rs;
    logic [7:0]  wd;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic [31:0] er;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ovf   = 1'b0;
    m_irq   = 1'b0;
  endtask

  task automatic model_edge(input logic sd, sc, ws, rs, input logic [7:0] wd, input logic rdy);
    int  old_size;
    bit  full, hs;
    old_size = mq.size();
    full     = (old_size == 16);
    hs       = m_valid && rdy;
    m_ovf    = (sd && ws && full) || (m_ovf && !(sc && rs));
    if (hs) void'(mq.pop_front());
    if (sd && ws && !full) mq.push_back(wd);
    if (m_valid) begin
      if (hs) begin
        if (mq.size() != 0) m_data = mq[0];
        else m_valid = 1'b0;
      end
    end else if (old_size != 0) begin
      m_valid = 1'b1;
      m_data  = mq[0];
    end
    m_irq = (mq.size() == 0) || m_ovf;
  endtask

  function automatic logic [31:0] model_status(input logic sc);
    logic [31:0] s;
    s = 32'h0;
    if (sc) begin
      s[10]  = m_ovf;
      s[9]   = (mq.size() == 16);
      s[8]   = m_valid;
      s[4:0] = 5'(mq.size());
    end
    return s;
  endfunction

  // One clock: drive at negedge, compare just after, then advance the model at posedge.
  task automatic step(input logic sd, sc, ws, rs, input logic [7:0] wd, input logic rdy);
    @(negedge clk);
    sel_dat = sd; sel_cntl = sc; wstrb = ws; rstrb = rs; wdata = wd; tx_ready = rdy;
    #1;
    got_valid = tx_valid;
    got_data  = tx_data;
    got_rdata = rdata;
    check("model_tx_valid", {31'b0, tx_valid}, {31'b0, m_valid});
    check("model_tx_data", {24'b0, tx_data}, {24'b0, m_data});
    check("model_rdata", rdata, model_status(sc));
`ifdef UART_TX_IRQ_EN
    check("model_irq", {31'b0, irq}, {31'b0, m_irq});
`endif
    @(posedge clk);
    model_edge(sd, sc, ws, rs, wd, rdy);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    sel_dat = 0; sel_cntl = 0; wstrb = 0; rstrb = 0; wdata = 0; tx_ready = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  logic [7:0] sent[$];
  logic       vseq[5];
  logic [7:0] dseq[5];

  initial begin
    // sd sc ws rs wd rdy | ev ed er
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 8'h00, 32'h000};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h001};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 32'h101};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 32'h000};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h41, 32'h000};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 8'h41, 32'h000};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 32'h000};

    // Reset values, single byte latency, ignored CNTL write / DATA read.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].sd, tbl[i].sc, tbl[i].ws, tbl[i].rs, tbl[i].wd, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), {31'b0, got_valid}, {31'b0, tbl[i].ev});
      check($sformatf("tbl%0d_data", i), {24'b0, got_data}, {24'b0, tbl[i].ed});
      check($sformatf("tbl%0d_rdata", i), got_rdata, tbl[i].er);
    end

    // Overfill with the emitter stalled, then read-to-clear overflow.
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 0, 1, 0, 8'(i), 0);
    step(0, 1, 0, 1, 8'h00, 0);
    check("ovf_read_first", got_rdata, 32'h710);
    step(0, 1, 0, 0, 8'h00, 0);
    check("ovf_read_second", got_rdata, 32'h310);

    // Full FIFO: same-cycle pop does not make room for the push.
    step(1, 0, 1, 0, 8'hAA, 1);
    step(0, 1, 0, 0, 8'h00, 0);
    check("full_pushpop_rdata", got_rdata, 32'h50F);
    check("full_pushpop_data", {24'b0, got_data}, 32'h01);
    sent.delete();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 8'h00, 1);
      if (got_valid) sent.push_back(got_data);
    end
    check("drain_count", sent.size(), 15);
    for (int i = 0; i < sent.size() && i < 15; i++)
      check($sformatf("drain_byte%0d", i), {24'b0, sent[i]}, 32'(i + 1));

    // Three queued bytes leave on three consecutive handshakes.
    do_reset();
    step(1, 0, 1, 0, 8'hA1, 0);
    step(1, 0, 1, 0, 8'hB2, 0);
    step(1, 0, 1, 0, 8'hC3, 0);
    step(0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 8'h00, 1);
      vseq[i] = got_valid;
      dseq[i] = got_data;
    end
    check("b2b_v0", {31'b0, vseq[0]}, 32'h1);
    check("b2b_d0", {24'b0, dseq[0]}, 32'hA1);
    check("b2b_v1", {31'b0, vseq[1]}, 32'h1);
    check("b2b_d1", {24'b0, dseq[1]}, 32'hB2);
    check("b2b_v2", {31'b0, vseq[2]}, 32'h1);
    check("b2b_d2", {24'b0, dseq[2]}, 32'hC3);
    check("b2b_v3", {31'b0, vseq[3]}, 32'h0);

    // Asynchronous reset while a byte is being offered.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 8'h60 + 8'(i), 0);
    step(0, 0, 0, 0, 8'h00, 0);
    #2 resetn = 1'b0;
    #1 check("async_rst_valid", {31'b0, tx_valid}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00, 1);
    check("post_rst_rdata", got_rdata, 32'h0);
    check("post_rst_valid", {31'b0, got_valid}, 32'h0);

    // Random traffic: a stalled phase to provoke overflow, then a fast-drain phase.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic sd, sc, ws, rs, rdy;
      sd  = ($urandom_range(0, 99) < 45);
      sc  = !sd && ($urandom_range(0, 99) < 50);
      ws  = ($urandom_range(0, 99) < 80);
      rs  = ($urandom_range(0, 99) < 30);
      rdy = ($urandom_range(0, 99) < ((i < 300) ? 20 : 75));
      step(sd, sc, ws, rs, 8'($urandom), rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
